// File: rtl/ssd_sched_if.sv
// Bus between the display scheduler and its requesters: request/load/blink
// controls in, grant and seven-segment driver word/enable out.
interface ssd_sched_if #(
    parameter int N_SRC = 3
);
    logic [N_SRC-1:0]    REQ;
    logic [N_SRC-1:0]    LOAD;
    logic [16*N_SRC-1:0] WORDS;
    logic [N_SRC-1:0]    BLINK;
    logic                HOLD;
    logic [N_SRC-1:0]    GNT;
    logic [15:0]         WORD;
    logic                EN;

    modport master (
        output REQ, LOAD, WORDS, BLINK, HOLD,
        input  GNT, WORD, EN
    );

    modport slave (
        input  REQ, LOAD, WORDS, BLINK, HOLD,
        output GNT, WORD, EN
    );
endinterface

// File: rtl/ssd_sched.sv
// Round-robin scheduler sharing one 4-digit seven-segment display between
// N_SRC requesters, with per-source word buffers, dwell timer, hold and blink.
module ssd_sched #(
    parameter int N_SRC      = 3,
    parameter int DWELL      = 12_000_000,
    parameter int BLINK_HALF = 6_000_000
) (
    input logic       CLK,
    input logic       RST,
    ssd_sched_if.slave bus
);
    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int DW = $clog2(DWELL);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [BW-1:0]   blink_q;
    logic            phase_q;
    logic [15:0]     buf_q [N_SRC];

    logic [IW-1:0]   base;
    logic [IW-1:0]   rr_idx;
    logic            rr_found;
    logic [N_SRC-1:0] gnt_d;
    logic            en_d;

    // Search g+1 .. g (wrapping); from IDLE the base is the top index so the
    // search starts at 0 and yields the lowest active requester.
    always_comb begin
        base     = (state_q == IDLE) ? IW'(N_SRC - 1) : idx_q;
        rr_idx   = base;
        rr_found = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (!rr_found && bus.REQ[(int'(base) + k) % N_SRC]) begin
                rr_found = 1'b1;
                rr_idx   = IW'((int'(base) + k) % N_SRC);
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        unique case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d = SHOW;
                    idx_d   = rr_idx;
                    dwell_d = '0;
                end
            end
            SHOW: begin
                if (!bus.REQ[idx_q]) begin
                    dwell_d = '0;
                    if (rr_found) idx_d = rr_idx;
                    else          state_d = IDLE;
                end else if (dwell_q == DW'(DWELL - 1)) begin
                    // Held at expiry: dwell saturates until HOLD drops.
                    if (!bus.HOLD) begin
                        idx_d   = rr_idx;
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_d = '0;
        if (state_d == SHOW) gnt_d[idx_d] = 1'b1;
        en_d = (state_d == SHOW) && !(bus.BLINK[idx_d] && phase_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            dwell_q  <= '0;
            blink_q  <= '0;
            phase_q  <= 1'b0;
            bus.GNT  <= '0;
            bus.WORD <= '0;
            bus.EN   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            if (blink_q == BW'(BLINK_HALF - 1)) begin
                blink_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                blink_q <= blink_q + BW'(1);
            end
            bus.GNT <= gnt_d;
            bus.EN  <= en_d;
            if (state_q == SHOW) bus.WORD <= buf_q[idx_q];
        end
    end

    // NOTE: the source buffers are small register arrays that must read as
    // zero after reset, so they carry the async reset unlike a RAM would.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_SRC; i++) buf_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++)
                if (bus.LOAD[i]) buf_q[i] <= bus.WORDS[16*i +: 16];
        end
    end
endmodule

// File: tb/tb_ssd_sched.sv
// Directed bench for ssd_sched (N_SRC=3, DWELL=8, BLINK_HALF=4); inputs
// change and outputs are sampled on the falling edge.
module tb_ssd_sched;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    ssd_sched_if #(.N_SRC(3)) bus ();

    ssd_sched #(.N_SRC(3), .DWELL(8), .BLINK_HALF(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Rising edges since the last reset release; drives the blink model.
    always @(posedge CLK or posedge RST)
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    logic [2:0]  gseq [4];
    logic [15:0] wseq [4];

    initial begin
        gseq = '{3'b001, 3'b010, 3'b100, 3'b001};
        wseq = '{16'h1111, 16'h2222, 16'h3333, 16'h1111};
        bus.REQ = '0; bus.LOAD = '0; bus.WORDS = '0; bus.BLINK = '0; bus.HOLD = 1'b0;

        // Reset values
        step(); step();
        check("rst_gnt", 32'(bus.GNT), 32'd0);
        check("rst_en", 32'(bus.EN), 32'd0);
        check("rst_word", 32'(bus.WORD), 32'd0);
        RST = 1'b0;

        // 1) Round robin across all three sources
        bus.LOAD = 3'b111;
        bus.WORDS = {16'h3333, 16'h2222, 16'h1111};
        bus.REQ = 3'b111;
        for (int s = 0; s < 4; s++) begin
            step();
            if (s == 0) bus.LOAD = '0;
            check("t1_gnt_change", 32'(bus.GNT), 32'(gseq[s]));
            check("t1_en", 32'(bus.EN), 32'd1);
            for (int k = 0; k < 7; k++) begin
                step();
                check("t1_gnt_hold", 32'(bus.GNT), 32'(gseq[s]));
                if (k == 0) check("t1_word", 32'(bus.WORD), 32'(wseq[s]));
            end
        end

        // 2) Single requester keeps the display
        bus.REQ = 3'b010;
        step();
        check("t2_gnt", 32'(bus.GNT), 32'b010);
        for (int k = 0; k < 30; k++) begin
            step();
            check("t2_gnt_hold", 32'(bus.GNT), 32'b010);
            check("t2_en", 32'(bus.EN), 32'd1);
            check("t2_word", 32'(bus.WORD), 32'h2222);
        end

        // 3) Request drop mid-dwell, dwell restart, then idle
        bus.REQ = 3'b001;
        step();
        check("t3_gnt_src0", 32'(bus.GNT), 32'b001);
        repeat (3) step();
        bus.REQ = 3'b100;
        step();
        check("t3_gnt_drop", 32'(bus.GNT), 32'b100);
        bus.REQ = 3'b101;
        for (int k = 0; k < 7; k++) begin
            step();
            check("t3_dwell_restart", 32'(bus.GNT), 32'b100);
            if (k == 0) check("t3_word", 32'(bus.WORD), 32'h3333);
        end
        bus.REQ = 3'b000;
        step();
        check("t3_idle_gnt", 32'(bus.GNT), 32'd0);
        check("t3_idle_en", 32'(bus.EN), 32'd0);
        check("t3_idle_word", 32'(bus.WORD), 32'h3333);
        step();
        check("t3_word_kept", 32'(bus.WORD), 32'h3333);

        // 4) HOLD suppresses rotation past dwell expiry
        bus.REQ = 3'b011;
        bus.HOLD = 1'b1;
        step();
        check("t4_gnt", 32'(bus.GNT), 32'b001);
        for (int k = 0; k < 20; k++) begin
            step();
            check("t4_hold", 32'(bus.GNT), 32'b001);
        end
        bus.HOLD = 1'b0;
        step();
        check("t4_release", 32'(bus.GNT), 32'b010);

        // 5) Blink on source 0, then load while granted
        bus.REQ = 3'b001;
        bus.BLINK = 3'b001;
        for (int k = 0; k < 17; k++) begin
            step();
            check("t5_gnt", 32'(bus.GNT), 32'b001);
            check("t5_en_blink", 32'(bus.EN), 32'((((cyc - 1) / 4) % 2) == 0));
        end
        bus.LOAD = 3'b001;
        bus.WORDS = {16'h3333, 16'h2222, 16'hABCD};
        step();
        bus.LOAD = '0;
        check("t5_word_old", 32'(bus.WORD), 32'h1111);
        step();
        check("t5_word_new", 32'(bus.WORD), 32'hABCD);

        // 6) Asynchronous reset mid-SHOW, then restart with cleared buffers
        bus.BLINK = '0;
        #2 RST = 1'b1;
        #1;
        check("t6_rst_gnt", 32'(bus.GNT), 32'd0);
        check("t6_rst_en", 32'(bus.EN), 32'd0);
        check("t6_rst_word", 32'(bus.WORD), 32'd0);
        bus.REQ = 3'b100;
        step();
        RST = 1'b0;
        step();
        check("t6_gnt", 32'(bus.GNT), 32'b100);
        check("t6_en", 32'(bus.EN), 32'd1);
        step();
        check("t6_word", 32'(bus.WORD), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
